// File: rtl/sa_pkg.sv
// Shared definitions for the 8x8 systolic-array feeder.
//   WIDTH     operand width per lane
//   N         lanes per side
//   FLUSH     zero-padded drain cycles after the last skewed beat
//   FLUSH_LEN cycles counted after FLUSH entry before COMMIT (N-1+FLUSH)
//   C_WIDTH   width of the flush cycle counter
//   state_t   feeder FSM states
//   lane()    extracts lane idx from a packed vector (lane 0 = MSBs)
package sa_pkg;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned N         = 8;
    localparam int unsigned FLUSH     = 3 * N - 2;
    localparam int unsigned FLUSH_LEN = N - 1 + FLUSH;
    localparam int unsigned C_WIDTH   = $clog2(FLUSH_LEN + 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush,
        StCommit
    } state_t;

    function automatic logic [WIDTH-1:0] lane(input logic [N*WIDTH-1:0] vec,
                                              input int unsigned      idx);
        return vec[(N - 1 - idx) * WIDTH +: WIDTH];
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Per-lane delay line: dout follows din after DEPTH+1 clocks.
//   clk   clock
//   rst   synchronous active-high reset, clears every stage
//   din   lane input
//   dout  lane output (DEPTH=0 is a single register)
module sa_skew_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i <= DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din;
            for (int unsigned i = 1; i <= DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DEPTH];

endmodule

// File: rtl/sa8_feeder.sv
// Input stage of the 8x8 systolic array: accepts K-slices (8 activations +
// 8 weights) over valid/ready, skews lane i by i cycles, zero-pads bubbles,
// drains the array after the last slice and pulses control to commit.
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      slice handshake (in_ready decoded from state)
//   in_act/in_weight       slice data, lane 0 = MSBs
//   in_last                last slice of tile
//   activation/weight      skewed data to the array
//   control                1-cycle commit pulse
//   busy                   state != IDLE
//   tile_beats             beats in the last completed tile
//   k_overflow             sticky: a tile was force-terminated at K_MAX
//   stall_cnt              (SA8_FEED_STALL_CNT_EN only) STREAM cycles without in_valid
module sa8_feeder
    import sa_pkg::*;
#(
    parameter  int unsigned K_MAX = 256,
    localparam int unsigned KW    = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*WIDTH-1:0] in_act,
    input  logic [N*WIDTH-1:0] in_weight,
    input  logic             in_last,
    output logic [N*WIDTH-1:0] activation,
    output logic [N*WIDTH-1:0] weight,
    output logic             control,
    output logic             busy,
    output logic [KW-1:0]    tile_beats,
`ifdef SA8_FEED_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic             k_overflow
);

    state_t               state_q, state_d;
    logic [KW-1:0]        k_q, k_d, k_inc;
    logic [C_WIDTH-1:0]   fcnt_q, fcnt_d;
    logic [KW-1:0]        tb_q, tb_d;
    logic                 ovf_q, ovf_d;
    logic                 control_q, busy_q;
    logic                 accept;

    assign in_ready = !rst && (state_q == StIdle || state_q == StStream);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        k_inc   = k_q;
        fcnt_d  = fcnt_q;
        tb_d    = tb_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StStream: begin
                if (accept) begin
                    k_inc = (state_q == StIdle) ? KW'(1) : k_q + KW'(1);
                    k_d   = k_inc;
                    if (in_last || k_inc == KW'(K_MAX)) begin
                        state_d = StFlush;
                        fcnt_d  = '0;
                        if (!in_last) begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StFlush: begin
                // Entry cycle plus FLUSH_LEN counted cycles drains the deepest lane.
                if (fcnt_q == C_WIDTH'(FLUSH_LEN)) begin
                    state_d = StCommit;
                    tb_d    = k_q;
                end else begin
                    fcnt_d = fcnt_q + C_WIDTH'(1);
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            fcnt_q    <= '0;
            tb_q      <= '0;
            ovf_q     <= 1'b0;
            control_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            fcnt_q    <= fcnt_d;
            tb_q      <= tb_d;
            ovf_q     <= ovf_d;
            control_q <= (state_d == StCommit);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign control    = control_q;
    assign busy       = busy_q;
    assign tile_beats = tb_q;
    assign k_overflow = ovf_q;

`ifdef SA8_FEED_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == StIdle && state_d == StStream) begin
            stall_d = '0;
        end else if (state_q == StStream && !in_valid && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    // Non-accepted cycles feed zeros so bubbles and drain appear as zero diagonals.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0] act_in, wgt_in;

        assign act_in = accept ? lane(in_act, i) : '0;
        assign wgt_in = accept ? lane(in_weight, i) : '0;

        sa_skew_line #(
            .WIDTH(WIDTH),
            .DEPTH(i)
        ) u_act (
            .clk  (clk),
            .rst  (rst),
            .din  (act_in),
            .dout (activation[(N-1-i)*WIDTH +: WIDTH])
        );

        sa_skew_line #(
            .WIDTH(WIDTH),
            .DEPTH(i)
        ) u_wgt (
            .clk  (clk),
            .rst  (rst),
            .din  (wgt_in),
            .dout (weight[(N-1-i)*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_sa8_feeder.sv
// Self-checking bench for sa8_feeder (K_MAX overridden to 16). A tile-level
// reference model schedules each accepted lane value at accept+1+lane and
// predicts handshake, busy, commit pulse and status outputs every cycle.
module tb_sa8_feeder;

    localparam int unsigned K_MAX = 16;
    localparam int unsigned KW    = $clog2(K_MAX + 1);
    localparam int          DRAIN = 31; // last accept to commit: N-1+FLUSH+2
    localparam int          NCYC  = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_act;
    logic [63:0]   in_weight;
    logic          in_last;
    logic [63:0]   activation;
    logic [63:0]   weight;
    logic          control;
    logic          busy;
    logic [KW-1:0] tile_beats;
    logic          k_overflow;
`ifdef SA8_FEED_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    sa8_feeder #(
        .K_MAX(K_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_act     (in_act),
        .in_weight  (in_weight),
        .in_last    (in_last),
        .activation (activation),
        .weight     (weight),
        .control    (control),
        .busy       (busy),
        .tile_beats (tile_beats),
`ifdef SA8_FEED_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .k_overflow (k_overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] exp_a [NCYC][8];
    logic [7:0] exp_w [NCYC][8];
    int         cyc;
    int         pend;        // cycle of the scheduled commit pulse, -1 if none
    int         pend_beats;
    int         beats;
    bit         in_tile;     // first beat taken, tile not yet terminated
    int         exp_tb;
    bit         exp_ovf;
    int         exp_stall;
    bit         last_acc;
    int         n_tests;
    int         n_fail;
    int         acc_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, want);
        end
    endtask

    function automatic logic [63:0] kv(input int k);
        logic [63:0] v;
        logic [3:0]  kk, ii;
        kk = 4'(k);
        for (int i = 0; i < 8; i++) begin
            ii = 4'(i);
            v[(7-i)*8 +: 8] = {kk, ii};
        end
        return v;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle: drive inputs, check outputs of this cycle, advance the model.
    task automatic step(input logic v, input logic l, input logic r,
                        input logic [63:0] a, input logic [63:0] w);
        logic [63:0] ea, ew;
        logic        er, eb, ec;
        bit          was_idle;
        if (pend >= 0 && cyc == pend) exp_tb = pend_beats;
        in_valid  = v;
        in_last   = l;
        rst       = r;
        in_act    = a;
        in_weight = w;
        #1;
        er = !r && (pend < 0);
        eb = in_tile || (pend >= 0);
        ec = (pend >= 0) && (cyc == pend);
        for (int i = 0; i < 8; i++) begin
            ea[(7-i)*8 +: 8] = exp_a[cyc][i];
            ew[(7-i)*8 +: 8] = exp_w[cyc][i];
        end
        chk("activation", activation, ea);
        chk("weight", weight, ew);
        chk("control", {63'd0, control}, {63'd0, ec});
        chk("busy", {63'd0, busy}, {63'd0, eb});
        chk("in_ready", {63'd0, in_ready}, {63'd0, er});
        chk("tile_beats", 64'(tile_beats), 64'(exp_tb));
        chk("k_overflow", {63'd0, k_overflow}, {63'd0, exp_ovf});
`ifdef SA8_FEED_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif
        last_acc = 0;
        if (r) begin
            for (int d = 1; d <= 9; d++) begin
                for (int i = 0; i < 8; i++) begin
                    exp_a[cyc+d][i] = 8'h00;
                    exp_w[cyc+d][i] = 8'h00;
                end
            end
            in_tile   = 0;
            pend      = -1;
            beats     = 0;
            exp_tb    = 0;
            exp_ovf   = 0;
            exp_stall = 0;
        end else begin
            if (pend >= 0 && cyc == pend) pend = -1;
            if (in_tile && !v) exp_stall++;
            if (v && er) begin
                last_acc = 1;
                was_idle = !in_tile;
                for (int i = 0; i < 8; i++) begin
                    exp_a[cyc+1+i][i] = a[(7-i)*8 +: 8];
                    exp_w[cyc+1+i][i] = w[(7-i)*8 +: 8];
                end
                beats   = was_idle ? 1 : beats + 1;
                in_tile = 1;
                if (l || beats == int'(K_MAX)) begin
                    if (!l) exp_ovf = 1;
                    pend       = cyc + DRAIN;
                    pend_beats = beats;
                    in_tile    = 0;
                end
                if (was_idle && in_tile) exp_stall = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, rnd64(), rnd64());
    endtask

    initial begin
        bit [7:0] pat;
        int       len;
        int       got;
        n_tests = 0;
        n_fail  = 0;
        pend    = -1;
        beats   = 0;
        in_tile = 0;
        exp_tb  = 0;
        exp_ovf = 0;
        exp_stall = 0;
        for (int c = 0; c < NCYC; c++) begin
            for (int i = 0; i < 8; i++) begin
                exp_a[c][i] = 8'h00;
                exp_w[c][i] = 8'h00;
            end
        end
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_act = '0; in_weight = '0;
        @(posedge clk);
        #1;
        cyc = 0;
        step(1'b0, 1'b0, 1'b1, '0, '0);   // reset cycle: in_ready must be low

        // 1: K=4 back-to-back, lane value {k,i}
        for (int k = 0; k < 4; k++) step(1'b1, k == 3, 1'b0, kv(k), ~kv(k));
        idle(36);

        // 2: single-beat tile
        step(1'b1, 1'b1, 1'b0, rnd64(), rnd64());
        idle(36);

        // 3: K=6 with bubbles in slots 2 and 4
        pat = 8'b1110_1011;
        for (int j = 0; j < 8; j++) step(pat[j], j == 7, 1'b0, rnd64(), rnd64());
        idle(36);

        // 4: 20 beats without in_last, forced termination at K_MAX
        acc_cnt = 0;
        for (int j = 0; j < 200 && acc_cnt < 20; j++) begin
            step(1'b1, 1'b0, 1'b0, rnd64(), rnd64());
            acc_cnt += int'(last_acc);
        end
        chk("t4_accepted", 64'(acc_cnt), 64'd20);
        idle(2);

        // 5: reset mid-STREAM, then a tile reset in its 3rd FLUSH cycle
        step(1'b0, 1'b0, 1'b1, rnd64(), rnd64());
        for (int k = 0; k < 3; k++) step(1'b1, k == 2, 1'b0, rnd64(), rnd64());
        idle(2);
        step(1'b0, 1'b0, 1'b1, rnd64(), rnd64());
        idle(40);

        // 6: two tiles with in_valid held high
        acc_cnt = 0;
        for (int j = 0; j < 200 && acc_cnt < 8; j++) begin
            step(1'b1, acc_cnt == 4 || acc_cnt == 7, 1'b0, rnd64(), rnd64());
            acc_cnt += int'(last_acc);
        end
        chk("t6_accepted", 64'(acc_cnt), 64'd8);
        idle(36);

        // Random tiles with random bubbles
        for (int t = 0; t < 3; t++) begin
            len = int'($urandom_range(1, 10));
            got = 0;
            for (int j = 0; j < 100 && got < len; j++) begin
                step($urandom_range(0, 3) != 0, got == len - 1, 1'b0, rnd64(), rnd64());
                got += int'(last_acc);
            end
            chk("rand_accepted", 64'(got), 64'(len));
            idle(36);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
